// File: rtl/disp_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : disp_cmd_pkg
// Brief    : Shared opcodes, FSM encoding, default geometry and RAM word
//            layout for the text-mode display path (decoder + pixel generator).
// Revision : 1.0 - initial release
// ============================================================================
package disp_cmd_pkg;

  // Default text-mode geometry and character/attribute defaults
  localparam int unsigned DEF_COLS       = 100;
  localparam int unsigned DEF_ROWS       = 37;
  localparam logic [7:0]  DEF_BLANK_CHAR = 8'h20;
  localparam logic [7:0]  DEF_ATTR_RESET = 8'h07;

  // Command opcodes; anything above OP_CLEAR is undefined
  localparam logic [7:0] OP_NOP      = 8'h00;
  localparam logic [7:0] OP_SET_ROW  = 8'h01;
  localparam logic [7:0] OP_SET_COL  = 8'h02;
  localparam logic [7:0] OP_SET_ATTR = 8'h03;
  localparam logic [7:0] OP_PUT_CHAR = 8'h04;
  localparam logic [7:0] OP_CLEAR    = 8'h05;

  // Decoder state encoding
  typedef enum logic [1:0] {
    ST_OPCODE = 2'd0,
    ST_ARG    = 2'd1,
    ST_CLEAR  = 2'd2
  } state_e;

  // Character RAM word: attribute in the upper byte, character in the lower
  typedef struct packed {
    logic [7:0] attr;
    logic [7:0] chr;
  } ram_word_t;

  function automatic ram_word_t make_word(input logic [7:0] attr, input logic [7:0] chr);
    ram_word_t w;
    w.attr = attr;
    w.chr  = chr;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/disp_cmd_if.sv
`default_nettype none
// ============================================================================
// Module   : disp_cmd_if
// Brief    : Byte-stream command channel from the FIFO reader to the decoder.
//            The reader strobes cmd_valid only while cmd_ready is high.
// Revision : 1.0 - initial release
// ============================================================================
interface disp_cmd_if;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;

  modport master (output cmd_data, output cmd_valid, input  cmd_ready);
  modport slave  (input  cmd_data, input  cmd_valid, output cmd_ready);
endinterface
`default_nettype wire

// File: rtl/disp_cursor.sv
`default_nettype none
// ============================================================================
// Module   : disp_cursor
// Brief    : Cursor row/column register with clamped load, wrapping advance
//            and home, plus the linear RAM address row*COLS+col.
// Revision : 1.0 - initial release
// ============================================================================
module disp_cursor
  import disp_cmd_pkg::*;
#(
  parameter int unsigned COLS   = DEF_COLS,
  parameter int unsigned ROWS   = DEF_ROWS,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              home,
  input  logic              load_row,
  input  logic              load_col,
  input  logic              advance,
  input  logic [7:0]        arg,
  output logic [7:0]        row,
  output logic [7:0]        col,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [7:0] ROW_MAX = 8'(ROWS - 1);
  localparam logic [7:0] COL_MAX = 8'(COLS - 1);

  logic [7:0] row_d, row_q;
  logic [7:0] col_d, col_q;

  // Next cursor: home beats load, load beats advance (only one is ever active)
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (home) begin
      row_d = '0;
      col_d = '0;
    end else if (load_row) begin
      row_d = (arg > ROW_MAX) ? ROW_MAX : arg;
    end else if (load_col) begin
      col_d = (arg > COL_MAX) ? COL_MAX : arg;
    end else if (advance) begin
      if (col_q == COL_MAX) begin
        col_d = '0;
        row_d = (row_q == ROW_MAX) ? 8'd0 : row_q + 8'd1;
      end else begin
        col_d = col_q + 8'd1;
      end
    end
  end

  // Cursor registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign addr = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);

endmodule
`default_nettype wire

// File: rtl/disp_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : disp_cmd_decoder
// Brief    : Text-mode command decoder. Turns the command byte stream into
//            cursor/attribute updates and single-cycle character RAM writes,
//            including a full-screen CLEAR sweep during which input is refused.
// Revision : 1.0 - initial release
// ============================================================================
module disp_cmd_decoder
  import disp_cmd_pkg::*;
#(
  parameter int unsigned COLS       = DEF_COLS,
  parameter int unsigned ROWS       = DEF_ROWS,
  parameter int unsigned ADDR_W     = 12,
  parameter logic [7:0]  BLANK_CHAR = DEF_BLANK_CHAR,
  parameter logic [7:0]  ATTR_RESET = DEF_ATTR_RESET
) (
  input  logic              clk,
  input  logic              nrst,
  disp_cmd_if.slave         cmd,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic [7:0]        cur_row,
  output logic [7:0]        cur_col,
  output logic [7:0]        cur_attr,
  output logic              drop_err,
  output logic              opcode_err
);

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(ROWS * COLS - 1);

  state_e            state_d, state_q;
  logic [7:0]        opcode_d, opcode_q;
  logic [ADDR_W-1:0] clr_cnt_d, clr_cnt_q;
  logic              cmd_ready_d, cmd_ready_q;
  logic              mem_we_d, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_d, mem_addr_q;
  logic [15:0]       mem_wdata_d, mem_wdata_q;
  logic [7:0]        attr_d, attr_q;
  logic              drop_err_d, drop_err_q;
  logic              opcode_err_d, opcode_err_q;

  logic              accept;
  logic              cur_home, cur_load_row, cur_load_col, cur_advance;
  logic [ADDR_W-1:0] cur_addr;

  disp_cursor #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_cursor (
    .clk      (clk),
    .nrst     (nrst),
    .home     (cur_home),
    .load_row (cur_load_row),
    .load_col (cur_load_col),
    .advance  (cur_advance),
    .arg      (cmd.cmd_data),
    .row      (cur_row),
    .col      (cur_col),
    .addr     (cur_addr)
  );

  assign accept = cmd.cmd_valid & cmd_ready_q;

  // Next-state, command execution and RAM write generation
  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    clr_cnt_d    = clr_cnt_q;
    cmd_ready_d  = cmd_ready_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    attr_d       = attr_q;
    drop_err_d   = drop_err_q | (cmd.cmd_valid & ~cmd_ready_q);
    opcode_err_d = opcode_err_q;
    cur_home     = 1'b0;
    cur_load_row = 1'b0;
    cur_load_col = 1'b0;
    cur_advance  = 1'b0;

    case (state_q)
      ST_OPCODE: begin
        if (accept) begin
          opcode_d = cmd.cmd_data;
          case (cmd.cmd_data)
            OP_SET_ROW, OP_SET_COL, OP_SET_ATTR, OP_PUT_CHAR: state_d = ST_ARG;
            OP_CLEAR: begin
              state_d     = ST_CLEAR;
              clr_cnt_d   = '0;
              cmd_ready_d = 1'b0;
            end
            OP_NOP: ;
            default: opcode_err_d = 1'b1;
          endcase
        end
      end

      ST_ARG: begin
        if (accept) begin
          state_d = ST_OPCODE;
          case (opcode_q)
            OP_SET_ROW:  cur_load_row = 1'b1;
            OP_SET_COL:  cur_load_col = 1'b1;
            OP_SET_ATTR: attr_d       = cmd.cmd_data;
            OP_PUT_CHAR: begin
              // Address uses the cursor before this cycle's advance
              mem_we_d    = 1'b1;
              mem_addr_d  = cur_addr;
              mem_wdata_d = make_word(attr_q, cmd.cmd_data);
              cur_advance = 1'b1;
            end
            default: ;
          endcase
        end
      end

      ST_CLEAR: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = clr_cnt_q;
        mem_wdata_d = make_word(attr_q, BLANK_CHAR);
        clr_cnt_d   = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == CLR_LAST) begin
          cur_home    = 1'b1;
          cmd_ready_d = 1'b1;
          state_d     = ST_OPCODE;
        end
      end

      default: state_d = ST_OPCODE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= ST_OPCODE;
      opcode_q     <= OP_NOP;
      clr_cnt_q    <= '0;
      cmd_ready_q  <= 1'b1;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      attr_q       <= ATTR_RESET;
      drop_err_q   <= 1'b0;
      opcode_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      clr_cnt_q    <= clr_cnt_d;
      cmd_ready_q  <= cmd_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      attr_q       <= attr_d;
      drop_err_q   <= drop_err_d;
      opcode_err_q <= opcode_err_d;
    end
  end

  assign cmd.cmd_ready = cmd_ready_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign cur_attr      = attr_q;
  assign drop_err      = drop_err_q;
  assign opcode_err    = opcode_err_q;

endmodule
`default_nettype wire
